mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter: RD_LAT, 2, read latency in cycles from request acceptance to data delivery; legal range 1..4.
REQ-002 SHALL have port: CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: memCLR  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: memRD  input  1  read request, sampled only in IDLE.
REQ-005 SHALL have port: memWR  input  1  write request, sampled only in IDLE.
REQ-006 SHALL have port: memAR  input  12  word address.
REQ-007 SHALL have port: memIN  input  16  write data.
REQ-008 SHALL have port: memOUT  output  16  read data, fed to the data register's inDR.
REQ-009 SHALL have port: drLD  output  1  one-cycle load strobe to the data register's drLD.
REQ-010 SHALL have port: memRDY  output  1  one-cycle completion pulse for reads and writes.
REQ-011 SHALL have port: memBUSY  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port: memERR  output  1  read parity error flag; constant 0 without MEM_PARITY_EN.
REQ-013 SHALL have port: memPINJ  input  1  parity-inject test input; present only with MEM_PARITY_EN.

Function
REQ-014 SHALL contain a 4096 x 16 storage array indexed by memAR; no out-of-range addresses exist.
REQ-015 SHALL implement states IDLE, RWAIT, WRITE, DONE.
REQ-016 IDLE, memRD=1 at edge N: latch memAR, load wait counter with RD_LAT-1, go RWAIT.
REQ-017 IDLE, memWR=1 (memRD=0) at edge N: latch memAR and memIN, go WRITE.
REQ-018 memRD and memWR both 1 in IDLE: read accepted, write dropped, no array change.
REQ-019 RWAIT: counter decrements each edge; at the edge where counter is 0, memOUT <= array[latched address], go DONE.
REQ-020 Read accepted at edge N SHALL give memOUT valid and drLD=memRDY=1 in the cycle after edge N+RD_LAT.
REQ-021 WRITE: at edge N+1, array[latched address] <= latched data, go DONE; memRDY=1, drLD=0 in DONE.
REQ-022 DONE SHALL last exactly one cycle, then IDLE; earliest next request sampled at edge following DONE.
REQ-023 memRD/memWR asserted outside IDLE SHALL be ignored, not queued.
REQ-024 memOUT SHALL hold the last read value until the next read completes; writes never alter memOUT.
REQ-025 A read of an address written by the immediately preceding completed write SHALL return the new data.
REQ-026 drLD and memRDY SHALL never be high for more than one consecutive cycle per request.

Reset
REQ-027 memCLR=1 at an edge SHALL force IDLE, memOUT=0, drLD=0, memRDY=0, memBUSY=0, memERR=0, counter=0.
REQ-028 Reset SHALL take priority over all requests and over the WRITE array update on the same edge; an aborted write leaves the array unchanged.
REQ-029 Array contents SHALL NOT be cleared by reset; initial contents undefined.

Configuration
REQ-030 Macro MEM_PARITY_EN defined: array 4096 x 17; on write, bit 16 = even parity of data XOR memPINJ (latched with memIN).
REQ-031 With MEM_PARITY_EN: in DONE after a read, memERR=1 if stored bit 16 mismatches recomputed parity; memERR cleared on next accepted request or reset; memOUT still delivered.
REQ-032 MEM_PARITY_EN undefined: array 16 bits wide, no memPINJ port, memERR tied 0.

Verification
REQ-033 Reset, write 0xBEEF to 0x123, read 0x123 with RD_LAT=2 -> memOUT=0xBEEF, drLD=memRDY=1 for one cycle, 2 cycles after read acceptance edge.
REQ-034 memRD=memWR=1 in IDLE, addr 0x000 holding 0x1111, memIN=0x2222 -> read returns 0x1111; subsequent read still 0x1111.
REQ-035 memRD pulsed during RWAIT at another address -> ignored; single drLD pulse; memBUSY high from acceptance through DONE.
REQ-036 memCLR asserted in WRITE of 0xAAAA to 0xFFF previously 0x5555 -> memOUT=0, IDLE next cycle; later read of 0xFFF returns 0x5555.
REQ-037 RWAIT with RD_LAT=1 and RD_LAT=4, write/read 0x0001 at 0x800 -> drLD in cycle after edge N+1 and N+4 respectively.
REQ-038 With MEM_PARITY_EN: write 0x0F0F to 0x010 with memPINJ=1, read 0x010 -> memOUT=0x0F0F, memERR=1; rewrite with memPINJ=0, read -> memERR=0.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port 4096-word memory controller with a fixed read latency.
// A read is accepted in IDLE, waits RD_LAT cycles and then delivers memOUT
// together with a one-cycle drLD/memRDY pulse. A write takes one cycle plus
// DONE. Requests that arrive outside IDLE are dropped, not queued.
// Optional feature: define MEM_PARITY_EN to widen the array to 17 bits,
// store an even-parity bit (which memPINJ can corrupt) and report
// read-back mismatches on memERR.
module mem_ctrl #(
    parameter int RD_LAT = 2
) (
    input  logic        CLK,
    input  logic        memCLR,
    input  logic        memRD,
    input  logic        memWR,
    input  logic [11:0] memAR,
    input  logic [15:0] memIN,
`ifdef MEM_PARITY_EN
    input  logic        memPINJ,
`endif
    output logic [15:0] memOUT,
    output logic        drLD,
    output logic        memRDY,
    output logic        memBUSY,
    output logic        memERR
);

    localparam int DEPTH = 4096;
    localparam int CNT_W = 2;
`ifdef MEM_PARITY_EN
    localparam int WORD_W = 17;
`else
    localparam int WORD_W = 16;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RWAIT = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [11:0]       addr_q;      // address latched at request acceptance
    logic [WORD_W-1:0] wword_q;     // write word (data plus parity when enabled)
    logic              is_rd_q;     // current transaction is a read
    logic [CNT_W-1:0]  cnt;         // read wait counter

    logic              accept_rd;
    logic              accept_wr;
    logic              rd_load;
    logic              mem_we;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;

    logic [WORD_W-1:0] mem [DEPTH];

    // Requests are only looked at in IDLE; a simultaneous read wins over a write.
    assign accept_rd = (state == IDLE) && memRD;
    assign accept_wr = (state == IDLE) && memWR && !memRD;

    // The read data is captured on the edge where the wait counter has run out.
    assign rd_load   = (state == RWAIT) && (cnt == '0);

    // A reset on the WRITE edge aborts the array update.
    assign mem_we    = (state == WRITE) && !memCLR;

`ifdef MEM_PARITY_EN
    // Bit 16 holds even parity of the data; memPINJ flips it to model a fault.
    assign wr_word   = {(^memIN) ^ memPINJ, memIN};
`else
    assign wr_word   = memIN;
`endif

    assign rd_word   = mem[addr_q];

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: clocked blocks use non-blocking assignments so every register
        // samples the values from before the edge, regardless of block order.
        if (memCLR) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic for the request/wait/complete sequence.
    always_comb begin
        // NOTE: next_state gets a default before the case so no path can leave
        // it unassigned, which would otherwise infer a latch.
        next_state = state;
        unique case (state)
            IDLE: begin
                if (memRD) begin
                    next_state = RWAIT;
                end else if (memWR) begin
                    next_state = WRITE;
                end
            end
            RWAIT: begin
                if (cnt == '0) begin
                    next_state = DONE;
                end
            end
            WRITE:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Latch address, write word and transaction type when a request is accepted.
    always_ff @(posedge CLK) begin
        if (memCLR) begin
            addr_q  <= '0;
            wword_q <= '0;
            is_rd_q <= 1'b0;
        end else if (accept_rd) begin
            addr_q  <= memAR;
            is_rd_q <= 1'b1;
        end else if (accept_wr) begin
            addr_q  <= memAR;
            wword_q <= wr_word;
            is_rd_q <= 1'b0;
        end
    end

    // Read wait counter: loaded with RD_LAT-1 on acceptance, counts down in RWAIT.
    always_ff @(posedge CLK) begin
        if (memCLR) begin
            cnt <= '0;
        end else if (accept_rd) begin
            cnt <= CNT_W'(RD_LAT - 1);
        end else if ((state == RWAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Storage array write port.
    always_ff @(posedge CLK) begin
        // NOTE: the array deliberately has no reset; its contents survive
        // memCLR and start out undefined.
        if (mem_we) begin
            mem[addr_q] <= wword_q;
        end
    end

    // Read data register: holds the last read value until the next read completes.
    always_ff @(posedge CLK) begin
        if (memCLR) begin
            memOUT <= '0;
        end else if (rd_load) begin
            memOUT <= rd_word[15:0];
        end
    end

`ifdef MEM_PARITY_EN
    logic err_q;

    // Parity error flag: set when a read completes with bad parity, cleared on
    // the next accepted request.
    always_ff @(posedge CLK) begin
        if (memCLR) begin
            err_q <= 1'b0;
        end else if (accept_rd || accept_wr) begin
            err_q <= 1'b0;
        end else if (rd_load) begin
            err_q <= ^rd_word;
        end
    end

    assign memERR = err_q;
`else
    assign memERR = 1'b0;
`endif

    // Completion strobes are decoded from the single DONE cycle.
    assign memRDY  = (state == DONE);
    assign drLD    = (state == DONE) && is_rd_q;
    assign memBUSY = (state != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl. Three instances (RD_LAT = 1, 2, 4) run
// from one clock; each has its own inputs. A word-level model per instance
// (array contents, parity-inject record, last delivered read value) supplies
// every expected value; cycle timing is derived from RD_LAT directly.
module tb_mem_ctrl;

    logic              clk;
    logic [2:0]        clr;
    logic [2:0]        rd;
    logic [2:0]        wr;
    logic [2:0][11:0]  ar;
    logic [2:0][15:0]  din;
    logic [2:0][15:0]  dout;
    logic [2:0]        dld;
    logic [2:0]        rdy;
    logic [2:0]        busy;
    logic [2:0]        err;
`ifdef MEM_PARITY_EN
    logic [2:0]        pinj;
`endif

    int vectors;
    int miscompares;

    // Reference model
    logic [15:0] model_d [3][4096];
    logic        model_p [3][4096];
    logic [15:0] last_out [3];
    logic [11:0] wq [$];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_ctrl #(.RD_LAT(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
            .CLK     (clk),
            .memCLR  (clr[g]),
            .memRD   (rd[g]),
            .memWR   (wr[g]),
            .memAR   (ar[g]),
            .memIN   (din[g]),
`ifdef MEM_PARITY_EN
            .memPINJ (pinj[g]),
`endif
            .memOUT  (dout[g]),
            .drLD    (dld[g]),
            .memRDY  (rdy[g]),
            .memBUSY (busy[g]),
            .memERR  (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    task automatic check(input string tag, input int k,
                         input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s [dut%0d]: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs(input int k);
        rd[k]  = 1'b0;
        wr[k]  = 1'b0;
        ar[k]  = '0;
        din[k] = '0;
`ifdef MEM_PARITY_EN
        pinj[k] = 1'b0;
`endif
    endtask

    function automatic logic exp_err(input int k, input logic [11:0] a);
`ifdef MEM_PARITY_EN
        return model_p[k][a];
`else
        return 1'b0;
`endif
    endfunction

    task automatic reset_all();
        clr = 3'b111;
        for (int k = 0; k < 3; k++) clear_inputs(k);
        tick();
        tick();
        clr = 3'b000;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_out",  k, dout[k], 32'h0);
            check("rst_drld", k, dld[k],  32'h0);
            check("rst_rdy",  k, rdy[k],  32'h0);
            check("rst_busy", k, busy[k], 32'h0);
            check("rst_err",  k, err[k],  32'h0);
            last_out[k] = 16'h0;
        end
    endtask

    task automatic write_op(input int k, input logic [11:0] a,
                            input logic [15:0] d, input bit inj);
        tick();
        wr[k] = 1'b1; ar[k] = a; din[k] = d;
`ifdef MEM_PARITY_EN
        pinj[k] = inj;
`endif
        tick();                       // acceptance edge
        clear_inputs(k);
        @(negedge clk);
        check("wr_busy",  k, busy[k], 32'h1);
        check("wr_rdy0",  k, rdy[k],  32'h0);
        check("wr_err0",  k, err[k],  32'h0);
        tick();                       // array update edge
        @(negedge clk);
        check("wr_done_rdy",  k, rdy[k],  32'h1);
        check("wr_done_drld", k, dld[k],  32'h0);
        check("wr_done_busy", k, busy[k], 32'h1);
        check("wr_done_out",  k, dout[k], {16'h0, last_out[k]});
        tick();
        @(negedge clk);
        check("wr_idle_rdy",  k, rdy[k],  32'h0);
        check("wr_idle_busy", k, busy[k], 32'h0);
        model_d[k][a] = d;
        model_p[k][a] = inj;
    endtask

    // Read with optional simultaneous write (dropped) and an optional
    // request pulse to another address during the wait (ignored).
    task automatic read_op(input int k, input logic [11:0] a, input bit also_wr,
                           input logic [15:0] wdata, input bit poke);
        logic [15:0] exp_d;
        int          lat;
        exp_d = model_d[k][a];
        lat   = lat_of(k);
        tick();
        rd[k] = 1'b1; ar[k] = a;
        wr[k] = also_wr; din[k] = wdata;
        tick();                       // acceptance edge N
        if (poke) begin
            rd[k] = 1'b1; wr[k] = 1'b1;
            ar[k] = a ^ 12'h5A5; din[k] = 16'hDEAD;
        end else begin
            clear_inputs(k);
        end
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            check("rd_wait_busy", k, busy[k], 32'h1);
            check("rd_wait_drld", k, dld[k],  32'h0);
            check("rd_wait_rdy",  k, rdy[k],  32'h0);
            if (c == 0) check("rd_wait_err", k, err[k], 32'h0);
            tick();
            if (c == 0) clear_inputs(k);
        end
        @(negedge clk);               // cycle after edge N+RD_LAT
        check("rd_done_drld", k, dld[k],  32'h1);
        check("rd_done_rdy",  k, rdy[k],  32'h1);
        check("rd_done_busy", k, busy[k], 32'h1);
        check("rd_done_out",  k, dout[k], {16'h0, exp_d});
        check("rd_done_err",  k, err[k],  {31'h0, exp_err(k, a)});
        tick();
        @(negedge clk);
        check("rd_idle_drld", k, dld[k],  32'h0);
        check("rd_idle_rdy",  k, rdy[k],  32'h0);
        check("rd_idle_busy", k, busy[k], 32'h0);
        check("rd_hold_out",  k, dout[k], {16'h0, exp_d});
        last_out[k] = exp_d;
    endtask

    task automatic write_abort(input int k, input logic [11:0] a, input logic [15:0] d);
        tick();
        wr[k] = 1'b1; ar[k] = a; din[k] = d;
        tick();                       // acceptance edge, now in WRITE
        clear_inputs(k);
        clr[k] = 1'b1;
        @(negedge clk);
        check("abort_busy", k, busy[k], 32'h1);
        tick();                       // reset edge replaces the array update
        clr[k] = 1'b0;
        @(negedge clk);
        check("abort_out",  k, dout[k], 32'h0);
        check("abort_busy0", k, busy[k], 32'h0);
        check("abort_rdy",  k, rdy[k],  32'h0);
        check("abort_drld", k, dld[k],  32'h0);
        check("abort_err",  k, err[k],  32'h0);
        last_out[k] = 16'h0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clr = 3'b111;
        for (int k = 0; k < 3; k++) clear_inputs(k);

        reset_all();

        // Basic write then read, RD_LAT = 2
        write_op(1, 12'h123, 16'hBEEF, 1'b0);
        read_op(1, 12'h123, 1'b0, 16'h0, 1'b0);

        // Simultaneous read and write: read wins, write dropped
        write_op(1, 12'h000, 16'h1111, 1'b0);
        read_op(1, 12'h000, 1'b1, 16'h2222, 1'b0);
        read_op(1, 12'h000, 1'b0, 16'h0, 1'b0);

        // Requests during RWAIT ignored; the poked write must not land
        read_op(1, 12'h123, 1'b0, 16'h0, 1'b1);
        read_op(1, 12'h123 ^ 12'h5A5, 1'b0, 16'h0, 1'b0);
        read_op(1, 12'h000, 1'b0, 16'h0, 1'b0);

        // Reset during WRITE aborts the update
        write_op(1, 12'hFFF, 16'h5555, 1'b0);
        read_op(1, 12'hFFF, 1'b0, 16'h0, 1'b0);
        write_abort(1, 12'hFFF, 16'hAAAA);
        read_op(1, 12'hFFF, 1'b0, 16'h0, 1'b0);

        // Latency extremes
        write_op(0, 12'h800, 16'h0001, 1'b0);
        read_op(0, 12'h800, 1'b0, 16'h0, 1'b0);
        write_op(2, 12'h800, 16'h0001, 1'b0);
        read_op(2, 12'h800, 1'b0, 16'h0, 1'b1);

`ifdef MEM_PARITY_EN
        // Parity injection flags the read; a clean rewrite clears it
        write_op(1, 12'h010, 16'h0F0F, 1'b1);
        read_op(1, 12'h010, 1'b0, 16'h0, 1'b0);
        write_op(1, 12'h010, 16'h0F0F, 1'b0);
        read_op(1, 12'h010, 1'b0, 16'h0, 1'b0);
`endif

        // Randomized traffic per instance
        for (int k = 0; k < 3; k++) begin
            wq.delete();
            for (int i = 0; i < 24; i++) begin
                if (wq.size() == 0 || $urandom_range(0, 1) == 0) begin
                    logic [11:0] a;
                    a = 12'($urandom_range(0, 4095));
                    write_op(k, a, 16'($urandom), 1'($urandom_range(0, 1)));
                    wq.push_back(a);
                end else begin
                    read_op(k, wq[$urandom_range(0, wq.size() - 1)],
                            1'($urandom_range(0, 1)), 16'($urandom),
                            1'($urandom_range(0, 1)));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
